// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key_event press-event decoder.
//
// Contents:
//   key_state_e        - decoder FSM state encoding (IDLE=0, PRESSED=1, LONG=2)
//   DefaultLongTicks   - default hold length before a long press is reported
//   DefaultRepeatTicks - default spacing of auto-repeat pulses
//   DefaultCntW        - default hold-counter width
//   max_ticks()        - larger of two tick thresholds, used to size-check the counter
package key_event_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StLong    = 2'd2
  } key_state_e;

  localparam int unsigned DefaultLongTicks   = 50;
  localparam int unsigned DefaultRepeatTicks = 10;
  localparam int unsigned DefaultCntW        = 8;

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// key_hold_timer: tick-enabled hold counter with synchronous clear and a
// terminal-match strobe. One instance serves both the long-press and the
// auto-repeat threshold; the caller selects which limit applies.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   en    - count enable (already qualified with the timebase tick)
//   clr   - synchronous clear, dominates en
//   limit - terminal count for the current phase
//   last  - high when the next enabled increment would reach limit; the
//           counter returns to 0 instead of reaching it, so it never wraps
module key_hold_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the compare is exact even when cnt_q is all ones.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last    = (cnt_inc == {1'b0, limit});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event.sv
// key_event: press-event decoder placed after a key debouncer. Turns one
// debounced, active-high key level into single-cycle press, release,
// long-press and (optionally) auto-repeat pulses plus a held flag.
//
// Build option:
//   KEY_EVENT_REPEAT_EN - when defined, the repeat counter and the
//                         repeat_pulse port are compiled in; otherwise the
//                         LONG state is terminal until release.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset
//   tick          - timebase enable strobe (tie high for clock-cycle timing)
//   key_level     - debounced key, 1 = pressed (already registered)
//   press_pulse   - one cycle on the press edge
//   release_pulse - one cycle on the release edge
//   long_pulse    - one cycle when the hold reaches LONG_TICKS
//   repeat_pulse  - one cycle every REPEAT_TICKS while in long hold (option)
//   held          - high while the decoder is not idle
// All outputs come straight from flops.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DefaultLongTicks,
  parameter int unsigned REPEAT_TICKS = DefaultRepeatTicks,
  parameter int unsigned CNT_W        = DefaultCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
`ifdef KEY_EVENT_REPEAT_EN
  output logic repeat_pulse,
`endif
  output logic held
);

  // Elaboration-time parameter sanity checks.
  if (LONG_TICKS < 2) begin : g_bad_long
    $error("key_event: LONG_TICKS must be at least 2");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("key_event: REPEAT_TICKS must be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(max_ticks(LONG_TICKS, REPEAT_TICKS))) begin : g_bad_cnt_w
    $error("key_event: CNT_W too narrow for the tick thresholds");
  end

  key_state_e state_q, state_d;
  logic       key_q;

  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic held_q, held_d;
`ifdef KEY_EVENT_REPEAT_EN
  logic repeat_q, repeat_d;
`endif

  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_limit;

  // The counter measures the long threshold while PRESSED and the repeat
  // spacing once LONG; it is cleared on every state change.
  assign cnt_limit = (state_q == StLong) ? CNT_W'(REPEAT_TICKS) : CNT_W'(LONG_TICKS);

  key_hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (cnt_limit),
    .last  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      StIdle: begin
        if (key_level && !key_q) begin
          state_d = StPressed;
          press_d = 1'b1;
          cnt_clr = 1'b1;
        end
      end

      StPressed: begin
        // Release is checked first so it always beats a threshold hit.
        if (!key_level) begin
          state_d   = StIdle;
          release_d = 1'b1;
          cnt_clr   = 1'b1;
        end else if (tick) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = StLong;
            long_d  = 1'b1;
          end
        end
      end

      StLong: begin
        if (!key_level) begin
          state_d   = StIdle;
          release_d = 1'b1;
          cnt_clr   = 1'b1;
        end else begin
`ifdef KEY_EVENT_REPEAT_EN
          cnt_en   = tick;
          repeat_d = tick && cnt_last;
`endif
        end
      end

      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_level;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`endif

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign held          = held_q;

endmodule

// File: doc/key_event.md
# key_event

Press-event decoder downstream of the button debouncer. Consumes one debounced, active-high key level and emits single-cycle press, release, long-press and auto-repeat pulses plus a held flag, so that FSM and counter logic never edge-detect raw key levels themselves. One instance per key, in the top-level input path between the debouncer and the control logic.

## Interface
- `LONG_TICKS`, 50: ticks the key must stay pressed before `long_pulse`; legal range ≥2.
- `REPEAT_TICKS`, 10: ticks between successive `repeat_pulse`s after `long_pulse`; legal range ≥1.
- `CNT_W`, 8: hold-counter width; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: timebase enable, one-cycle strobe from a prescaler; tie to 1 for clock-cycle timing.
- `key_level` in 1: debounced key, 1 = pressed; already registered, so no synchronizer is needed.
- `press_pulse` out 1: one cycle on the press edge.
- `release_pulse` out 1: one cycle on the release edge.
- `long_pulse` out 1: one cycle when the hold reaches `LONG_TICKS`.
- `repeat_pulse` out 1: one cycle every `REPEAT_TICKS` while in long hold; only exists with the macro.
- `held` out 1: 1 while the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: waiting for a press.
  - PRESSED: press seen, long threshold not yet reached.
  - LONG: long threshold reached.
- Registers: `key_q` (previous `key_level`), `cnt[CNT_W-1:0]`, state, and all outputs.
- IDLE → PRESSED:
  - Condition: `key_level`=1 and `key_q`=0 at an edge.
  - Actions: `press_pulse`=1, `cnt`=0.
- PRESSED:
  - Each edge with `tick`=1 and `key_level`=1 increments `cnt`.
  - When the increment would make `cnt` == `LONG_TICKS`: `long_pulse`=1, state → LONG, `cnt`=0.
- LONG, with the macro:
  - `cnt` increments on `tick`.
  - When the increment reaches `REPEAT_TICKS`: `repeat_pulse`=1, `cnt`=0.
- LONG, without the macro: `cnt` holds at 0.
- Any non-IDLE state with `key_level`=0 at an edge:
  - `release_pulse`=1, state → IDLE, `cnt`=0.
- Simultaneous events:
  - Release and threshold on the same edge: release wins; no `long_pulse` or `repeat_pulse` that cycle.
  - `tick`=0 freezes `cnt` but never delays press or release detection.
- `key_level` already 1 when reset deasserts (`key_q` resets to 0): treated as a press on the first edge after reset.
- Pulses are mutually exclusive. At most one of press/release/long/repeat is high in any cycle.
- `cnt` never exceeds max(LONG_TICKS, REPEAT_TICKS) − 1 and never wraps.

## Timing
- Reset values:
  - state = IDLE; `key_q`, `cnt` = 0.
  - `press_pulse`, `release_pulse`, `long_pulse`, `repeat_pulse`, `held` = 0.
- Reset mid-hold: all outputs are 0 the cycle after the reset edge. No `release_pulse` is emitted.
- Latencies with `tick`=1 and key sampled high first at edge E:
  - Press: `press_pulse` and `held` registered at E, visible the cycle after.
  - Long: `long_pulse` at edge E+LONG_TICKS.
  - Repeat: `repeat_pulse` at E+LONG_TICKS+k·REPEAT_TICKS, k ≥ 1.
- Release: key first sampled low at edge F → `release_pulse` at F; `held` falls at F.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `KEY_EVENT_REPEAT_EN` defined:
  - The repeat counter and `repeat_pulse` logic are compiled in.
  - The `repeat_pulse` port exists.
- `KEY_EVENT_REPEAT_EN` undefined:
  - The `repeat_pulse` port and its logic are absent.
  - LONG is terminal until release; `REPEAT_TICKS` is ignored.

## Structure
- Shared package `key_event_pkg`:
  - State encoding constants: IDLE=2'd0, PRESSED=2'd1, LONG=2'd2.
  - Default tick constants.
- Sub-module `key_hold_timer`: `CNT_W` counter with tick enable, synchronous clear and terminal-match strobe, reused for both thresholds.
- Edge detection and the FSM stay in `key_event`.

## Test plan
- Short press:
  - Stimulus: tick=1, LONG_TICKS=5; key high at edge 10, low at edge 13.
  - Response: press at 10, release at 13, no long; `held` high for cycles 10–12.
- Long press with repeat (macro on, REPEAT_TICKS=3):
  - Stimulus: key high from edge 10 to 25.
  - Response: press at 10, long at 15, repeat at 18/21/24, release at 25.
- Release on the threshold edge:
  - Stimulus: key low exactly at edge 15 (the LONG_TICKS=5 edge).
  - Response: release only at 15; no long_pulse.
- Tick gating:
  - Stimulus: tick every 4th cycle, LONG_TICKS=2; press at an edge between ticks.
  - Response: long_pulse on the second tick edge after the press.
- Reset mid-hold:
  - Stimulus: rst high during LONG.
  - Response: all outputs 0 next cycle and no release_pulse. With key still high after rst drops, press_pulse on the first edge.
- Macro off:
  - Stimulus: long hold of 40 cycles.
  - Response: exactly one long_pulse and zero repeat activity.
